np_exp_prep: RTL and testbench

NP_EXP_PREP -- requirements
Module: np_exp_prep

---
 rtl/np_exp_pkg.sv | 19 +
 rtl/np_shift_dly.sv | 36 +++
 rtl/np_exp_prep.sv | 174 +++++++++++++++++
 tb/tb_np_exp_prep.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/np_exp_pkg.sv
// np_exp_pkg: Q16.16 constants and k typing shared by np_exp_prep and the CORDIC exp stage chain.
package np_exp_pkg;

    localparam int unsigned NP_DATA_WIDTH = 32;
    localparam int unsigned NP_FRAC_BITS  = 16;
    localparam logic [31:0] NP_INV_LN2    = 32'd94548;
    localparam logic [31:0] NP_LN2        = 32'd45426;
    localparam logic [31:0] NP_X_INIT     = 32'd79135;
    localparam int unsigned NP_K_W        = 8;

    typedef logic signed [NP_K_W-1:0] k_t;

    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_HI   = 2'd1,
        CLAMP_LO   = 2'd2
    } clamp_e;

endpackage

// File: rtl/np_shift_dly.sv
// np_shift_dly: DEPTH-stage data+valid shift register; every stage clears on synchronous reset.
module np_shift_dly #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data  [DEPTH];
    logic             r_valid [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else begin
            r_data[0]  <= i_data;
            r_valid[0] <= i_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/np_exp_prep.sv
// np_exp_prep: 3-stage range reduction z = k*ln2 + r feeding a CORDIC exp chain.
// Define NP_EXP_PREP_KDLY_EN to route k_out/k_valid through a KDLY-deep np_shift_dly.
module np_exp_prep
    import np_exp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NP_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = NP_FRAC_BITS,
    parameter logic [31:0] INV_LN2    = NP_INV_LN2,
    parameter logic [31:0] LN2        = NP_LN2,
    parameter logic [31:0] X_INIT     = NP_X_INIT,
    parameter int          K_MIN      = -15,
    parameter int          K_MAX      = 15,
    parameter int unsigned KDLY       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] z_in,
    input  logic                         sat_clr,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] x_out,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic signed [DATA_WIDTH-1:0] z_out,
    output logic                         k_valid,
    output logic signed [NP_K_W-1:0]     k_out,
    output logic [15:0]                  sat_cnt
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] C_INV  = DATA_WIDTH'(INV_LN2);
    localparam logic signed [DATA_WIDTH-1:0] C_LN2  = DATA_WIDTH'(LN2);
    localparam logic signed [DATA_WIDTH-1:0] C_XIN  = DATA_WIDTH'(X_INIT);
    localparam logic signed [PW-1:0]         C_KMIN = PW'(K_MIN);
    localparam logic signed [PW-1:0]         C_KMAX = PW'(K_MAX);

    // stage 1: product z*(1/ln2)
    logic                         r_v1;
    logic signed [DATA_WIDTH-1:0] r_z1;
    logic signed [PW-1:0]         r_prod1;
    logic signed [PW-1:0]         w_prod;

    assign w_prod = PW'(z_in) * PW'(C_INV);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_z1    <= '0;
            r_prod1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_z1    <= z_in;
                r_prod1 <= w_prod;
            end
        end
    end

    // stage 2: floor to integer k, then clamp to the supported exponent range
    logic                         r_v2;
    logic signed [DATA_WIDTH-1:0] r_z2;
    k_t                           r_k2;
    clamp_e                       r_clamp2;
    logic signed [PW-1:0]         w_kr;
    k_t                           w_k;
    clamp_e                       w_clamp;

    assign w_kr = r_prod1 >>> (2 * FRAC_BITS);

    always_comb begin
        w_clamp = CLAMP_NONE;
        w_k     = k_t'(w_kr);
        if (w_kr > C_KMAX) begin
            w_clamp = CLAMP_HI;
            w_k     = k_t'(K_MAX);
        end else if (w_kr < C_KMIN) begin
            w_clamp = CLAMP_LO;
            w_k     = k_t'(K_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_z2     <= '0;
            r_k2     <= '0;
            r_clamp2 <= CLAMP_NONE;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_z2     <= r_z1;
                r_k2     <= w_k;
                r_clamp2 <= w_clamp;
            end
        end
    end

    // stage 3: residual r = z - k*ln2; clamped samples pin r to the range edge
    logic                         r_ov;
    logic signed [DATA_WIDTH-1:0] r_x;
    logic signed [DATA_WIDTH-1:0] r_y;
    logic signed [DATA_WIDTH-1:0] r_r;
    k_t                           r_k3;
    logic [15:0]                  r_sat_cnt;
    logic signed [DATA_WIDTH-1:0] w_r;
    logic                         w_sat;

    assign w_sat = (r_clamp2 != CLAMP_NONE);

    always_comb begin
        w_r = r_z2 - DATA_WIDTH'(r_k2) * C_LN2;
        if (r_clamp2 == CLAMP_HI) begin
            w_r = C_LN2 - DATA_WIDTH'(1);
        end else if (r_clamp2 == CLAMP_LO) begin
            w_r = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
            r_r  <= '0;
            r_k3 <= '0;
        end else begin
            r_ov <= r_v2;
            if (r_v2) begin
                r_x  <= C_XIN;
                r_y  <= '0;
                r_r  <= w_r;
                r_k3 <= r_k2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_v2 && w_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign out_valid = r_ov;
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign z_out     = r_r;
    assign sat_cnt   = r_sat_cnt;

`ifdef NP_EXP_PREP_KDLY_EN
    logic              w_kv_dly;
    logic [NP_K_W-1:0] w_k_dly;

    np_shift_dly #(
        .WIDTH (NP_K_W),
        .DEPTH (KDLY)
    ) u_k_dly (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_ov),
        .i_data  (r_k3),
        .o_valid (w_kv_dly),
        .o_data  (w_k_dly)
    );

    assign k_valid = w_kv_dly;
    assign k_out   = w_k_dly;
`else
    assign k_valid = r_ov;
    assign k_out   = r_k3;
`endif

endmodule

// File: tb/tb_np_exp_prep.sv
// tb_np_exp_prep: directed and pseudo-random vectors for np_exp_prep, with a cycle-stamped scoreboard.
// Build with +define+NP_EXP_PREP_KDLY_EN to check the delayed k path.
module tb_np_exp_prep;
    import np_exp_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               sat_clr;
    logic signed [31:0] z_in;
    logic               out_valid;
    logic signed [31:0] x_out;
    logic signed [31:0] y_out;
    logic signed [31:0] z_out;
    logic               k_valid;
    logic signed [7:0]  k_out;
    logic [15:0]        sat_cnt;

    int n_chk = 0;
    int n_err = 0;

    // expectation that travels with the sample currently driven
    int e_k;
    int e_z;
    bit e_sat;

    typedef struct {
        longint due;
        int     k;
        int     z;
        bit     sat;
    } exp_t;

    typedef struct {
        longint due;
        int     k;
    } kexp_t;

    exp_t   q[$];
    kexp_t  kq[$];
    longint cyc      = 0;
    int     n_out    = 0;
    logic   prev_rst = 1'b0;
    logic   prev_clr = 1'b0;
    int     m_sat    = 0;
    int     lz       = 0;
    int     lx       = 0;

    np_exp_prep #(
        .DATA_WIDTH (32),
        .FRAC_BITS  (16),
        .INV_LN2    (32'd94548),
        .LN2        (32'd45426),
        .X_INIT     (32'd79135),
        .K_MIN      (-15),
        .K_MAX      (15),
        .KDLY       (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .z_in      (z_in),
        .sat_clr   (sat_clr),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .k_valid   (k_valid),
        .k_out     (k_out),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference: floor(z/ln2) by integer division with explicit negative correction
    function automatic void ref_model(input int z, output int k, output int r, output bit s);
        longint p;
        longint qq;
        p  = longint'(z) * 64'sd94548;
        qq = p / 64'sd4294967296;
        if (p < 0 && qq * 64'sd4294967296 != p) qq = qq - 1;
        s = 1'b0;
        if (qq > 15) begin
            k = 15; r = 45425; s = 1'b1;
        end else if (qq < -15) begin
            k = -15; r = 0; s = 1'b1;
        end else begin
            k = int'(qq);
            r = z - k * 45426;
        end
    endfunction

    task automatic drive(input logic v, input int z, input int ek, input int ez, input bit es,
                         input logic clr, input logic r);
        in_valid = v;
        z_in     = z;
        e_k      = ek;
        e_z      = ez;
        e_sat    = es;
        sat_clr  = clr;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        kexp_t ke;
        bit    popped;
        popped = 1'b0;
        if (prev_rst) begin
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_x", x_out, 0);
            chk("post_rst_y", y_out, 0);
            chk("post_rst_z", z_out, 0);
            chk("post_rst_k", k_out, 0);
            chk("post_rst_k_valid", k_valid, 0);
            lz = 0;
            lx = 0;
        end else if (out_valid) begin
            n_out++;
            if (q.size() == 0) begin
                chk("out_valid_unexpected", out_valid, 0);
            end else begin
                e = q.pop_front();
                popped = 1'b1;
                chk("latency", cyc, e.due);
                chk("z_out", z_out, e.z);
                chk("x_out", x_out, 79135);
                chk("y_out", y_out, 0);
                lz = e.z;
                lx = 79135;
`ifdef NP_EXP_PREP_KDLY_EN
                kq.push_back('{cyc + 16, e.k});
`else
                chk("k_out", k_out, e.k);
`endif
            end
        end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                chk("out_valid_due", out_valid, 1);
                void'(q.pop_front());
            end
            chk("hold_z", z_out, lz);
            chk("hold_x", x_out, lx);
            chk("hold_y", y_out, 0);
        end

        if (!prev_rst) begin
`ifdef NP_EXP_PREP_KDLY_EN
            if (kq.size() > 0 && kq[0].due == cyc) begin
                ke = kq.pop_front();
                chk("k_valid_dly", k_valid, 1);
                chk("k_out_dly", k_out, ke.k);
            end else begin
                chk("k_valid_dly", k_valid, 0);
            end
`else
            chk("k_valid", k_valid, popped);
`endif
        end

        if (prev_rst || prev_clr) m_sat = 0;
        else if (popped && e.sat && m_sat < 65535) m_sat++;
        chk("sat_cnt", sat_cnt, m_sat);

        if (rst) begin
            q.delete();
            kq.delete();
        end else if (in_valid) begin
            q.push_back('{cyc + 3, e_k, e_z, e_sat});
        end
        prev_rst = rst;
        prev_clr = sat_clr;
        cyc++;
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; sat_clr = 1'b0; z_in = '0;
        e_k = 0; e_z = 0; e_sat = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 12345, 0, 0, 1'b0, 1'b0, 1'b1);   // valid during reset must vanish
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_z_out", z_out, 0);
        chk("reset_sat_cnt", sat_cnt, 0);

        // directed, back-to-back: {z_in, k, r}
        drive(1'b1, 0,        0,   0,     1'b0, 1'b0, 1'b0);
        drive(1'b1, 65536,    1,   20110, 1'b0, 1'b0, 1'b0);
        drive(1'b1, -65536,   -2,  25316, 1'b0, 1'b0, 1'b0);
        drive(1'b1, -1,       -1,  45425, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 720000,   15,  38610, 1'b0, 1'b0, 1'b0);
        drive(1'b1, -680000,  -15, 1390,  1'b0, 1'b0, 1'b0);
        idle(4);
        chk("sat_none", sat_cnt, 0);
        chk("x_seed_held", x_out, 79135);

        drive(1'b1, 1310720, 15, 45425, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("sat_after_hi", sat_cnt, 1);
        drive(1'b1, -1310720, -15, 0, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("sat_after_lo", sat_cnt, 2);

        // third clamp reaches stage 3 on the same edge sat_clr is sampled
        drive(1'b1, 1310720, 15, 45425, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("sat_clr_wins", sat_cnt, 0);
        idle(20);

        base = n_out;
        for (int i = 0; i < 100; i++) begin
            int z;
            int k;
            int r;
            bit s;
            z = int'($urandom_range(3000000)) - 1500000;
            ref_model(z, k, r, s);
            drive(1'b1, z, k, r, s, 1'b0, (i == 50));
        end
        idle(24);
        chk("rand_outputs", n_out - base, 97);
        chk("queue_drained", q.size(), 0);
        chk("kqueue_drained", kq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
